shot_collision_resolver: RTL and testbench

- Responder side of the player-shot interface. The player munition block reports an active shot and its position. This block decides whether the shot hit a living enemy in the 8x3 grid.
- On a hit it returns colisao_inimigo, kills that enemy in enemy_vivos and credits score.
- It sits between the player munition block, the enemy renderers (which consume enemy_vivos) and the score display.
- Evaluation is once per frame, scanning one enemy per clock.

---
 rtl/shot_collision_resolver_pkg.sv | 35 +++
 rtl/shot_collision_resolver_if.sv | 21 ++
 rtl/shot_collision_resolver_rect_overlap.sv | 22 ++
 rtl/shot_collision_resolver.sv | 142 ++++++++++++++
 tb/tb_shot_collision_resolver.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/shot_collision_resolver_pkg.sv
// Shared constants, state encoding and scoring table for the shot collision resolver.
package shot_collision_resolver_pkg;

    localparam int N_COLS    = 8;
    localparam int N_ROWS    = 3;
    localparam int N_ENEMIES = N_COLS * N_ROWS;
    localparam int IDX_W     = 5;
    localparam int COORD_IN_W = 11;
    localparam int COORD_W   = 13;

    localparam int ENEMY_W = 40;
    localparam int ENEMY_H = 30;
    localparam int SHOT_W  = 4;
    localparam int SHOT_H  = 12;

    localparam int PTS_R0 = 30;
    localparam int PTS_R1 = 20;
    localparam int PTS_R2 = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Points awarded for killing an enemy in the given row (row 0 is the top).
    function automatic logic [31:0] row_points(input logic [1:0] row);
        case (row)
            2'd0:    row_points = 32'(PTS_R0);
            2'd1:    row_points = 32'(PTS_R1);
            default: row_points = 32'(PTS_R2);
        endcase
    endfunction

endpackage

// File: rtl/shot_collision_resolver_if.sv
// Player-shot handshake between the munition block (master) and the resolver (slave).
interface shot_collision_resolver_if;
    import shot_collision_resolver_pkg::*;

    logic                   shot_active;
    logic [COORD_IN_W-1:0]  shot_x;
    logic [COORD_IN_W-1:0]  shot_y;
    logic                   colisao_inimigo;
    logic [IDX_W-1:0]       hit_index;

    modport master (
        output shot_active, shot_x, shot_y,
        input  colisao_inimigo, hit_index
    );

    modport slave (
        input  shot_active, shot_x, shot_y,
        output colisao_inimigo, hit_index
    );

endinterface

// File: rtl/shot_collision_resolver_rect_overlap.sv
// Combinational strict-overlap test of two signed axis-aligned rectangles.
module rect_overlap #(
    parameter int W = 13
) (
    input  logic signed [W-1:0] a_x_i,
    input  logic signed [W-1:0] a_y_i,
    input  logic signed [W-1:0] a_w_i,
    input  logic signed [W-1:0] a_h_i,
    input  logic signed [W-1:0] b_x_i,
    input  logic signed [W-1:0] b_y_i,
    input  logic signed [W-1:0] b_w_i,
    input  logic signed [W-1:0] b_h_i,
    output logic                overlap_o
);

    // Touching edges do not count as overlap; both axes must intersect.
    always_comb begin
        overlap_o = (a_x_i < b_x_i + b_w_i) && (b_x_i < a_x_i + a_w_i) &&
                    (a_y_i < b_y_i + b_h_i) && (b_y_i < a_y_i + a_h_i);
    end

endmodule

// File: rtl/shot_collision_resolver.sv
// Once-per-frame scan of the 8x3 enemy grid against the player shot, one enemy per clock.
module shot_collision_resolver
    import shot_collision_resolver_pkg::*;
#(
    parameter int X0        = 180,
    parameter int DX        = 80,
    parameter int Y0        = 40,
    parameter int DY        = 50,
    parameter int SCORE_MAX = 999
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    restart,
    input  logic                    frame_tick,
    input  logic [COORD_IN_W-1:0]   grid_off_x,
    input  logic [COORD_IN_W-1:0]   grid_off_y,
    shot_collision_resolver_if.slave shot_if,
    output logic [N_ENEMIES-1:0]    enemy_vivos,
    output logic [31:0]             score,
    output logic                    all_dead,
    output logic                    busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ENEMIES - 1);

    state_t                  state_q;
    logic [IDX_W-1:0]        idx_q;
    logic [COORD_IN_W-1:0]   sx_q, sy_q, offx_q, offy_q;
    logic [N_ENEMIES-1:0]    vivos_q;
    logic [31:0]             score_q;
    logic [IDX_W-1:0]        hit_index_q;
    logic                    colisao_q;
    logic                    all_dead_q;

    logic [2:0]              col;
    logic [1:0]              row;
    logic signed [COORD_W-1:0] ex_d, ey_d, sx_d, sy_d;
    logic                    overlap;
    logic                    hit_d;
    logic [31:0]             sum_d, score_d;

    // Position of the enemy under examination and of the latched shot, in signed 13-bit space.
    always_comb begin
        col  = idx_q[2:0];
        row  = idx_q[4:3];
        ex_d = $signed(COORD_W'(X0) + COORD_W'(col) * COORD_W'(DX) + {{2{offx_q[10]}}, offx_q});
        ey_d = $signed(COORD_W'(Y0) + COORD_W'(row) * COORD_W'(DY) + {2'b00, offy_q});
        sx_d = $signed({2'b00, sx_q});
        sy_d = $signed({2'b00, sy_q});
    end

    rect_overlap #(
        .W (COORD_W)
    ) u_overlap (
        .a_x_i     (sx_d),
        .a_y_i     (sy_d),
        .a_w_i     (COORD_W'(SHOT_W)),
        .a_h_i     (COORD_W'(SHOT_H)),
        .b_x_i     (ex_d),
        .b_y_i     (ey_d),
        .b_w_i     (COORD_W'(ENEMY_W)),
        .b_h_i     (COORD_W'(ENEMY_H)),
        .overlap_o (overlap)
    );

    // Hit qualification for the current index plus the saturated score after crediting it.
    always_comb begin
        hit_d   = (state_q == SCAN) && vivos_q[idx_q] && overlap &&
                  !ex_d[COORD_W-1] && !ey_d[COORD_W-1] && !all_dead_q;
        sum_d   = score_q + row_points(row);
        score_d = (sum_d > 32'(SCORE_MAX)) ? 32'(SCORE_MAX) : sum_d;
    end

    // Scan FSM with all game state and outputs registered; restart mirrors reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            sx_q        <= '0;
            sy_q        <= '0;
            offx_q      <= '0;
            offy_q      <= '0;
            vivos_q     <= '1;
            score_q     <= '0;
            hit_index_q <= '0;
            colisao_q   <= 1'b0;
            all_dead_q  <= 1'b0;
        end else if (restart) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            vivos_q     <= '1;
            score_q     <= '0;
            hit_index_q <= '0;
            colisao_q   <= 1'b0;
            all_dead_q  <= 1'b0;
        end else begin
            all_dead_q <= all_dead_q | ~|vivos_q;
            case (state_q)
                IDLE: begin
                    if (frame_tick && shot_if.shot_active) begin
                        sx_q    <= shot_if.shot_x;
                        sy_q    <= shot_if.shot_y;
                        offx_q  <= grid_off_x;
                        offy_q  <= grid_off_y;
                        idx_q   <= '0;
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    if (!shot_if.shot_active) begin
                        state_q <= IDLE;
                    end else if (hit_d) begin
                        vivos_q[idx_q] <= 1'b0;
                        hit_index_q    <= idx_q;
                        score_q        <= score_d;
                        colisao_q      <= 1'b1;
                        state_q        <= HOLD;
                    end else if (idx_q == LAST_IDX) begin
                        state_q <= IDLE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                HOLD: begin
                    if (!shot_if.shot_active) begin
                        colisao_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign shot_if.colisao_inimigo = colisao_q;
    assign shot_if.hit_index       = hit_index_q;
    assign enemy_vivos             = vivos_q;
    assign score                   = score_q;
    assign all_dead                = all_dead_q;
    assign busy                    = (state_q != IDLE);

endmodule

// File: tb/tb_shot_collision_resolver.sv
// Directed self-checking bench for shot_collision_resolver.
module tb_shot_collision_resolver;

    logic        clk;
    logic        reset;
    logic        restart;
    logic        frame_tick;
    logic [10:0] grid_off_x;
    logic [10:0] grid_off_y;
    logic [23:0] enemy_vivos,  enemy_vivos2;
    logic [31:0] score,        score2;
    logic        all_dead,     all_dead2;
    logic        busy,         busy2;

    int checks = 0;
    int errors = 0;

    shot_collision_resolver_if sif ();
    shot_collision_resolver_if sif2 ();

    // Second instance with a low ceiling so saturation is reachable within one game.
    assign sif2.shot_active = sif.shot_active;
    assign sif2.shot_x      = sif.shot_x;
    assign sif2.shot_y      = sif.shot_y;

    shot_collision_resolver dut (
        .clk         (clk),
        .reset       (reset),
        .restart     (restart),
        .frame_tick  (frame_tick),
        .grid_off_x  (grid_off_x),
        .grid_off_y  (grid_off_y),
        .shot_if     (sif),
        .enemy_vivos (enemy_vivos),
        .score       (score),
        .all_dead    (all_dead),
        .busy        (busy)
    );

    shot_collision_resolver #(
        .SCORE_MAX (50)
    ) dut_sat (
        .clk         (clk),
        .reset       (reset),
        .restart     (restart),
        .frame_tick  (frame_tick),
        .grid_off_x  (grid_off_x),
        .grid_off_y  (grid_off_y),
        .shot_if     (sif2),
        .enemy_vivos (enemy_vivos2),
        .score       (score2),
        .all_dead    (all_dead2),
        .busy        (busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic fire(input logic [10:0] x, input logic [10:0] y);
        sif.shot_x      = x;
        sif.shot_y      = y;
        sif.shot_active = 1'b1;
        frame_tick      = 1'b1;
        step();
        frame_tick      = 1'b0;
    endtask

    task automatic wait_hit(output int n);
        n = 0;
        while (!sif.colisao_inimigo && n < 40) begin
            step();
            n++;
        end
    endtask

    task automatic scan_len(output int n, output logic saw);
        n   = 0;
        saw = 1'b0;
        while (busy && n < 40) begin
            step();
            n++;
            if (sif.colisao_inimigo) saw = 1'b1;
        end
    endtask

    task automatic release_shot;
        sif.shot_active = 1'b0;
        step();
    endtask

    task automatic do_restart;
        restart = 1'b1;
        step();
        restart = 1'b0;
    endtask

    task automatic test_reset;
        checks++; if (enemy_vivos !== 24'hFFFFFF) begin errors++; $display("FAIL reset_vivos got %h exp %h", enemy_vivos, 24'hFFFFFF); end
        checks++; if (score !== 32'd0) begin errors++; $display("FAIL reset_score got %0d exp 0", score); end
        checks++; if (sif.colisao_inimigo !== 1'b0) begin errors++; $display("FAIL reset_colisao got %b exp 0", sif.colisao_inimigo); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (all_dead !== 1'b0) begin errors++; $display("FAIL reset_all_dead got %b exp 0", all_dead); end
        checks++; if (sif.hit_index !== 5'd0) begin errors++; $display("FAIL reset_hit_index got %0d exp 0", sif.hit_index); end
    endtask

    task automatic test_hit_first;
        int n;
        fire(11'd190, 11'd50);
        wait_hit(n);
        checks++; if (n != 1) begin errors++; $display("FAIL hit0_latency got %0d exp 1", n); end
        checks++; if (enemy_vivos !== 24'hFFFFFE) begin errors++; $display("FAIL hit0_vivos got %h exp FFFFFE", enemy_vivos); end
        checks++; if (score !== 32'd30) begin errors++; $display("FAIL hit0_score got %0d exp 30", score); end
        checks++; if (sif.hit_index !== 5'd0) begin errors++; $display("FAIL hit0_index got %0d exp 0", sif.hit_index); end
        frame_tick = 1'b1;
        repeat (3) step();
        frame_tick = 1'b0;
        checks++; if (sif.colisao_inimigo !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL hold_keeps got colisao=%b busy=%b exp 1 1", sif.colisao_inimigo, busy); end
        checks++; if (enemy_vivos !== 24'hFFFFFE || score !== 32'd30) begin errors++; $display("FAIL hold_ignores_tick got %h/%0d exp FFFFFE/30", enemy_vivos, score); end
        release_shot();
        checks++; if (sif.colisao_inimigo !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL hold_release got colisao=%b busy=%b exp 0 0", sif.colisao_inimigo, busy); end
    endtask

    task automatic test_hit_last;
        int   n;
        logic saw;
        fire(11'd750, 11'd150);
        wait_hit(n);
        checks++; if (n != 24) begin errors++; $display("FAIL hit23_latency got %0d exp 24", n); end
        checks++; if (enemy_vivos !== 24'h7FFFFE) begin errors++; $display("FAIL hit23_vivos got %h exp 7FFFFE", enemy_vivos); end
        checks++; if (score !== 32'd40) begin errors++; $display("FAIL hit23_score got %0d exp 40", score); end
        checks++; if (sif.hit_index !== 5'd23) begin errors++; $display("FAIL hit23_index got %0d exp 23", sif.hit_index); end
        release_shot();
        fire(11'd750, 11'd150);
        scan_len(n, saw);
        checks++; if (n != 24 || saw !== 1'b0) begin errors++; $display("FAIL dead23_rescan got len=%0d hit=%b exp 24 0", n, saw); end
        checks++; if (enemy_vivos !== 24'h7FFFFE || score !== 32'd40) begin errors++; $display("FAIL dead23_state got %h/%0d exp 7FFFFE/40", enemy_vivos, score); end
        release_shot();
    endtask

    task automatic test_miss_abort;
        int   n;
        logic saw;
        fire(11'd100, 11'd300);
        scan_len(n, saw);
        checks++; if (n != 24 || saw !== 1'b0) begin errors++; $display("FAIL miss_scan got len=%0d hit=%b exp 24 0", n, saw); end
        checks++; if (enemy_vivos !== 24'h7FFFFE || score !== 32'd40) begin errors++; $display("FAIL miss_state got %h/%0d exp 7FFFFE/40", enemy_vivos, score); end
        // Aim at enemy 10, drop the shot while idx is still 4.
        fire(11'd350, 11'd100);
        repeat (4) step();
        sif.shot_active = 1'b0;
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle got busy=%b exp 0", busy); end
        repeat (12) step();
        checks++; if (sif.colisao_inimigo !== 1'b0 || enemy_vivos !== 24'h7FFFFE || score !== 32'd40) begin
            errors++; $display("FAIL abort_nochange got colisao=%b %h/%0d exp 0 7FFFFE/40", sif.colisao_inimigo, enemy_vivos, score);
        end
    endtask

    task automatic test_offset;
        int   n;
        logic saw;
        do_restart();
        // Right edge of enemy 0 just touches the shot: not an overlap.
        fire(11'd220, 11'd50);
        scan_len(n, saw);
        checks++; if (n != 24 || saw !== 1'b0) begin errors++; $display("FAIL touch_edge got len=%0d hit=%b exp 24 0", n, saw); end
        release_shot();
        // Enemy 0 at x=-20 overlaps the shot but is partly off-screen.
        grid_off_x = 11'h738;
        fire(11'd0, 11'd50);
        scan_len(n, saw);
        checks++; if (n != 24 || saw !== 1'b0 || enemy_vivos !== 24'hFFFFFF) begin
            errors++; $display("FAIL negative_enemy got len=%0d hit=%b vivos=%h exp 24 0 FFFFFF", n, saw, enemy_vivos);
        end
        release_shot();
        grid_off_x = 11'h7EC;
        fire(11'd170, 11'd50);
        wait_hit(n);
        checks++; if (n != 1 || sif.hit_index !== 5'd0 || enemy_vivos !== 24'hFFFFFE) begin
            errors++; $display("FAIL offset_hit got lat=%0d idx=%0d vivos=%h exp 1 0 FFFFFE", n, sif.hit_index, enemy_vivos);
        end
        release_shot();
        grid_off_x = 11'd0;
    endtask

    task automatic test_saturation;
        int n;
        do_restart();
        fire(11'd190, 11'd50);
        wait_hit(n);
        release_shot();
        checks++; if (score !== 32'd30 || score2 !== 32'd30) begin errors++; $display("FAIL sat_first got %0d/%0d exp 30/30", score, score2); end
        fire(11'd270, 11'd50);
        wait_hit(n);
        checks++; if (n != 2) begin errors++; $display("FAIL sat_latency got %0d exp 2", n); end
        checks++; if (score !== 32'd60) begin errors++; $display("FAIL sat_unclamped got %0d exp 60", score); end
        checks++; if (score2 !== 32'd50) begin errors++; $display("FAIL sat_clamped got %0d exp 50", score2); end
        release_shot();
    endtask

    task automatic test_restart;
        int n;
        fire(11'd100, 11'd300);
        repeat (3) step();
        do_restart();
        checks++; if (enemy_vivos !== 24'hFFFFFF || score !== 32'd0 || busy !== 1'b0 || sif.colisao_inimigo !== 1'b0) begin
            errors++; $display("FAIL restart_scan got %h/%0d busy=%b col=%b exp FFFFFF/0 0 0", enemy_vivos, score, busy, sif.colisao_inimigo);
        end
        release_shot();
        fire(11'd190, 11'd50);
        wait_hit(n);
        checks++; if (busy !== 1'b1 || score !== 32'd30) begin errors++; $display("FAIL restart_pre_hold got busy=%b score=%0d exp 1 30", busy, score); end
        do_restart();
        checks++; if (enemy_vivos !== 24'hFFFFFF || score !== 32'd0 || busy !== 1'b0 || sif.colisao_inimigo !== 1'b0) begin
            errors++; $display("FAIL restart_hold got %h/%0d busy=%b col=%b exp FFFFFF/0 0 0", enemy_vivos, score, busy, sif.colisao_inimigo);
        end
        release_shot();
    endtask

    task automatic test_kill_all;
        int   n;
        int   bad;
        logic saw;
        bad = 0;
        do_restart();
        for (int unsigned k = 0; k < 24; k++) begin
            fire(11'(190 + 80 * (k % 8)), 11'(50 + 50 * (k / 8)));
            wait_hit(n);
            if (n != int'(k) + 1 || sif.hit_index !== 5'(k)) bad++;
            if (k == 23) begin
                checks++; if (all_dead !== 1'b0) begin errors++; $display("FAIL all_dead_early got %b exp 0", all_dead); end
            end
            release_shot();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL kill_sequence got %0d bad hits exp 0", bad); end
        checks++; if (all_dead !== 1'b1 || enemy_vivos !== 24'h0) begin errors++; $display("FAIL all_dead got %b vivos=%h exp 1 000000", all_dead, enemy_vivos); end
        checks++; if (score !== 32'd480) begin errors++; $display("FAIL kill_all_score got %0d exp 480", score); end
        fire(11'd190, 11'd50);
        scan_len(n, saw);
        checks++; if (n != 24 || saw !== 1'b0 || all_dead !== 1'b1) begin errors++; $display("FAIL all_dead_rescan got len=%0d hit=%b ad=%b exp 24 0 1", n, saw, all_dead); end
        release_shot();
        do_restart();
        checks++; if (all_dead !== 1'b0 || enemy_vivos !== 24'hFFFFFF) begin errors++; $display("FAIL all_dead_restart got %b %h exp 0 FFFFFF", all_dead, enemy_vivos); end
    endtask

    initial begin
        reset           = 1'b0;
        restart         = 1'b0;
        frame_tick      = 1'b0;
        grid_off_x      = 11'd0;
        grid_off_y      = 11'd0;
        sif.shot_active = 1'b0;
        sif.shot_x      = 11'd0;
        sif.shot_y      = 11'd0;
        repeat (3) step();
        reset = 1'b1;
        step();
        test_reset();
        test_hit_first();
        test_hit_last();
        test_miss_abort();
        test_offset();
        test_saturation();
        test_restart();
        test_kill_all();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
